// File: rtl/debounce_bank_pkg.sv
// Shared defaults and sizing helper for the switch debouncer bank.
package debounce_pkg;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 2**20;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/debounce_bank_channel.sv
// One switch channel: synchroniser, stability counter, debounced state and
// registered rise/fall pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic switch_i,
    output logic state_o,
    output logic rise_o,
    output logic fall_o,
    output logic pulse_d_o
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // Any agreement clears progress; only an unbroken run reaches TERM.
        if (sync_last != state_q) begin
            if (cnt_q == TERM) begin
                state_d = ~state_q;
                rise_d  = ~state_q;
                fall_d  = state_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q   <= '0;
            state_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], switch_i};
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign state_o   = state_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign pulse_d_o = rise_d | fall_d;
endmodule

// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers with output polarity control and a
// registered any-event summary aligned with the per-channel pulses.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit RESET_LEVEL     = 1'b0,
    parameter bit INVERT_OUT      = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] switch_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                event_o
);
    if (CHANNELS < 1)        begin : g_bad_channels $error("CHANNELS must be >= 1"); end
    if (SYNC_STAGES < 2)     begin : g_bad_sync     $error("SYNC_STAGES must be >= 2"); end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles   $error("DEBOUNCE_CYCLES must be >= 2"); end

    logic [CHANNELS-1:0] state;
    logic [CHANNELS-1:0] pulse_d;
    logic                event_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_ch (
            .clock     (clock),
            .reset_n   (reset_n),
            .switch_i  (switch_i[g]),
            .state_o   (state[g]),
            .rise_o    (rise_o[g]),
            .fall_o    (fall_o[g]),
            .pulse_d_o (pulse_d[g])
        );
    end

    // Built from next-cycle pulses so it lands in the same cycle as rise_o/fall_o.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) event_q <= 1'b0;
        else          event_q <= |pulse_d;
    end

    assign event_o = event_q;
    assign level_o = state ^ {CHANNELS{INVERT_OUT}};
endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios plus random
// switch activity, checked every cycle against a run-length reference model.
module tb_debounce_bank;
    localparam int CH  = 4;
    localparam int SS  = 2;
    localparam int DC  = 8;
    localparam bit RL  = 1'b0;
    localparam bit INV = 1'b1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [CH-1:0] sw;
    logic [CH-1:0] level_o, rise_o, fall_o;
    logic          event_o;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    // Reference model: each raw sample becomes visible SS edges later; a run of
    // DC consecutive visible samples that differ from the state flips it.
    logic          seen_q[CH][$];
    int            run[CH];
    logic [CH-1:0] st;
    logic [CH-1:0] exp_r, exp_f;
    logic          exp_e;

    debounce_bank #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
        .RESET_LEVEL(RL), .INVERT_OUT(INV)
    ) dut (
        .clock(clock), .reset_n(reset_n), .switch_i(sw),
        .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .event_o(event_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            seen_q[c].delete();
            for (int k = 0; k < SS; k++) seen_q[c].push_back(RL);
            run[c] = 0;
        end
        st    = {CH{RL}};
        exp_r = '0;
        exp_f = '0;
        exp_e = 1'b0;
    endtask

    task automatic check_outputs();
        chk("level", 32'(level_o), 32'(st ^ {CH{INV}}));
        chk("rise",  32'(rise_o),  32'(exp_r));
        chk("fall",  32'(fall_o),  32'(exp_f));
        chk("event", 32'(event_o), 32'(exp_e));
    endtask

    task automatic tick();
        logic v;
        @(posedge clock);
        edge_n++;
        if (!reset_n) model_reset();
        else begin
            exp_r = '0;
            exp_f = '0;
            for (int c = 0; c < CH; c++) begin
                v = seen_q[c].pop_front();
                seen_q[c].push_back(sw[c]);
                if (v != st[c]) begin
                    run[c]++;
                    if (run[c] == DC) begin
                        run[c] = 0;
                        if (v) exp_r[c] = 1'b1; else exp_f[c] = 1'b1;
                        st[c] = v;
                    end
                end else run[c] = 0;
            end
            exp_e = |(exp_r | exp_f);
        end
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the selected pulse appears on the watched lanes; returns the edge number or -1.
    task automatic wait_pulse(input logic [CH-1:0] mask, input bit rising, input int limit,
                              output int at, output logic [CH-1:0] seen);
        at = -1;
        seen = '0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (((rising ? rise_o : fall_o) & mask) != '0) begin
                at = edge_n;
                seen = rising ? rise_o : fall_o;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic [CH-1:0] val, input int cycles);
        sw = val;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        ticks(cycles);
        reset_n = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        int at;
        logic [CH-1:0] pv;
        int ev_cycles;
        reset_n = 1'b1;
        sw = '0;
        model_reset();
        @(negedge clock);

        // 1: reset with all switches high; outputs must sit at reset values
        do_reset(4'hF, 4);
        chk("reset_level", 32'(level_o), 32'h0000000F);

        // 2: clean press on ch0, sampled at edge 1
        do_reset(4'h0, 2);
        sw = 4'b0001;
        wait_pulse(4'b0001, 1'b1, 30, at, pv);
        chk("press_latency", 32'(at), 32'(SS + DC));
        chk("press_level0", 32'(level_o[0]), 32'd0);
        chk("press_event", 32'(event_o), 32'd1);
        tick();
        chk("press_event_1cyc", 32'(event_o), 32'd0);
        ticks(4);

        // 3: bounce on ch1 (7 high / 7 low x5), then an 8-cycle stable high
        for (int r = 0; r < 5; r++) begin
            sw[1] = 1'b1; ticks(7);
            sw[1] = 1'b0; ticks(7);
        end
        chk("bounce_level1", 32'(level_o[1]), 32'd1);
        sw[1] = 1'b1;
        ticks(8);
        sw[1] = 1'b0;
        ticks(2);
        chk("bounce_accept_level1", 32'(level_o[1]), 32'd0);
        sw[1] = 1'b1;
        ticks(12);

        // 4: simultaneous rise on ch2 and ch3
        sw[3:2] = 2'b11;
        wait_pulse(4'b1100, 1'b1, 30, at, pv);
        chk("simul_rise", 32'(pv), 32'hC);
        chk("simul_event", 32'(event_o), 32'd1);
        ev_cycles = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (event_o) ev_cycles++;
        end
        chk("simul_event_cycles", 32'(ev_cycles), 32'd1);

        // 5: release ch0
        sw[0] = 1'b0;
        edge_n = 0;
        wait_pulse(4'b0001, 1'b0, 30, at, pv);
        chk("release_latency", 32'(at), 32'(SS + DC));
        chk("release_level0", 32'(level_o[0]), 32'd1);
        ticks(4);

        // 6: reset mid-count on ch1; progress must be discarded
        sw = '0;
        ticks(20);
        sw[1] = 1'b1;
        ticks(SS + 5);
        do_reset(4'b0010, 2);
        wait_pulse(4'b0010, 1'b1, 30, at, pv);
        chk("reset_midcount_latency", 32'(at), 32'(SS + DC));

        // Random switch activity with varied hold times, checked every edge
        for (int s = 0; s < 120; s++) begin
            sw = sw ^ CH'($urandom_range(0, (1 << CH) - 1));
            ticks($urandom_range(1, 12));
        end
        ticks(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
